// File: rtl/pipe_ex_stage.sv
// Execute stage and EX/MEM pipeline register of the pipelined MIPS core.
// Resolves operand forwarding, computes the ALU result, resolves BEQ/BNE/J
// into a combinational fetch redirect, and registers MEM/WB controls.
module pipe_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic [31:0] instr,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   input  logic [31:0] imm_ext,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] pc_4,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        jump,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic        alu_src,
   input  logic [3:0]  alu_op,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_dest,
   input  logic [31:0] wb_data,
   output logic [31:0] exmem_alu_result,
   output logic [31:0] exmem_store_data,
   output logic [4:0]  exmem_wb_addr,
   output logic [31:0] exmem_instr,
   output logic        exmem_mem_read,
   output logic        exmem_mem_write,
   output logic        exmem_mem_to_reg,
   output logic        exmem_reg_write,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   logic [4:0]  rsAddr;
   logic [4:0]  rtAddr;
   logic [4:0]  shamt;
   logic [31:0] opA;
   logic [31:0] opRt;
   logic [31:0] opB;
   logic [31:0] aluResult;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;
   logic        zero;
   logic        taken;

   assign rsAddr = instr[25:21];
   assign rtAddr = instr[20:16];
   assign shamt  = instr[10:6];

   // Operand forwarding: EX/MEM beats MEM/WB; $0 is never forwarded.
   always_comb begin
      opA = read_data1;
      if (exmem_reg_write && (exmem_wb_addr != 5'd0) && (exmem_wb_addr == rsAddr)) begin
         opA = exmem_alu_result;
      end else if (wb_reg_write && (wb_dest != 5'd0) && (wb_dest == rsAddr)) begin
         opA = wb_data;
      end
      opRt = read_data2;
      if (exmem_reg_write && (exmem_wb_addr != 5'd0) && (exmem_wb_addr == rtAddr)) begin
         opRt = exmem_alu_result;
      end else if (wb_reg_write && (wb_dest != 5'd0) && (wb_dest == rtAddr)) begin
         opRt = wb_data;
      end
   end

   assign opB = alu_src ? imm_ext : opRt;

   // ALU; undefined operation codes yield zero.
   always_comb begin
      aluResult = 32'd0;
      case (alu_op)
         4'b0000: aluResult = opA & opB;
         4'b0001: aluResult = opA | opB;
         4'b0010: aluResult = opA + opB;
         4'b0011: aluResult = ~(opA | opB);
         4'b0100: aluResult = opA - opB;
         4'b0101: aluResult = {31'd0, $signed(opA) < $signed(opB)};
         4'b0110: aluResult = opB << shamt;
         4'b0111: aluResult = opB >> shamt;
         4'b1000: aluResult = {imm_ext[15:0], 16'd0};
         4'b1001: aluResult = opA ^ opB;
         default: aluResult = 32'd0;
      endcase
   end

   // Branch compare uses the forwarded rt even for immediate-form instructions.
   assign zero         = (opA == opRt);
   assign taken        = (branch_eq & zero) | (branch_ne & ~zero);
   assign branchTarget = pc_4 + {imm_ext[29:0], 2'b00};
   assign jumpTarget   = {pc_4[31:28], instr[25:0], 2'b00};

   // Redirect is suppressed during hold; the held branch fires once hold drops.
   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      if ((jump | taken) & ~hold & ~reset) begin
         redirect_valid = 1'b1;
         redirect_pc    = jump ? jumpTarget : branchTarget;
      end
   end

   // EX/MEM register, falling-edge like the rest of the pipeline; reset beats hold.
   always_ff @(negedge clk) begin
      if (reset) begin
         exmem_alu_result <= 32'd0;
         exmem_store_data <= 32'd0;
         exmem_wb_addr    <= 5'd0;
         exmem_instr      <= 32'd0;
         exmem_mem_read   <= 1'b0;
         exmem_mem_write  <= 1'b0;
         exmem_mem_to_reg <= 1'b0;
         exmem_reg_write  <= 1'b0;
      end else if (!hold) begin
         exmem_alu_result <= aluResult;
         exmem_store_data <= opRt;
         exmem_wb_addr    <= wb_addr;
         exmem_instr      <= instr;
         exmem_mem_read   <= mem_read;
         exmem_mem_write  <= mem_write;
         exmem_mem_to_reg <= mem_to_reg;
         exmem_reg_write  <= reg_write;
      end
   end

endmodule

// File: doc/pipe_ex_stage.md
# pipe_ex_stage

Execute stage plus EX/MEM pipeline register of the pipelined MIPS core. Consumes the ID/EX register outputs, resolves operand forwarding from EX/MEM and MEM/WB, and computes the ALU result. Resolves BEQ/BNE/J and issues a redirect to fetch, along with the ID/EX flush request. Registers memory and writeback controls for the MEM stage.

## Interface
Parameters:
- none (datapath fixed at 32 bits, register address 5 bits)

Ports:
- clk  in  1  pipeline clock; all registers update on the falling edge, matching the other pipeline registers
- reset  in  1  synchronous, active-high
- hold  in  1  downstream stall; EX/MEM register keeps its contents
- instr  in  32  ID/EX instruction
- read_data1, read_data2  in  32 each  ID/EX register operands (rs, rt)
- imm_ext  in  32  sign-extended immediate
- wb_addr  in  5  destination register
- pc_4  in  32  PC+4 of this instruction
- branch_eq, branch_ne, jump  in  1 each  branch/jump controls
- mem_read, mem_write, mem_to_reg, reg_write, alu_src  in  1 each  controls
- alu_op  in  4  ALU operation
- wb_reg_write  in  1  MEM/WB write enable (forwarding source)
- wb_dest  in  5  MEM/WB destination
- wb_data  in  32  MEM/WB writeback value
- exmem_alu_result  out  32  registered ALU result
- exmem_store_data  out  32  registered forwarded rt value
- exmem_wb_addr  out  5  registered destination
- exmem_instr  out  32  registered instruction
- exmem_mem_read, exmem_mem_write, exmem_mem_to_reg, exmem_reg_write  out  1 each  registered controls
- redirect_valid  out  1  taken branch or jump this cycle (combinational)
- redirect_pc  out  32  redirect target (combinational)

## Operation
- Register fields:
  - rs = instr[25:21], rt = instr[20:16], shamt = instr[10:6].
- Forwarding, per operand (rs and rt), in priority order:
  1. From exmem_alu_result if exmem_reg_write=1, exmem_wb_addr≠0 and exmem_wb_addr equals the operand address.
  2. Else from wb_data if wb_reg_write=1, wb_dest≠0 and wb_dest equals the operand address.
  3. Else read_data1 or read_data2.
- A load followed by a dependent instruction never reaches this stage back-to-back; upstream hazard logic inserts the bubble.
- ALU operands:
  - A = forwarded rs.
  - B = imm_ext if alu_src=1, else forwarded rt.
- alu_op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 NOR, 0100 SUB, 0101 SLT (signed, result 1/0).
  - 0110 SLL B by shamt, 0111 SRL B by shamt, 1000 LUI (imm_ext[15:0]<<16), 1001 XOR.
  - All other codes produce 0.
- Arithmetic is modulo 2^32; overflow is ignored.
- zero = (forwarded rs == forwarded rt), independent of alu_src.
- Branch taken when (branch_eq & zero) | (branch_ne & ~zero).
- Branch target = pc_4 + (imm_ext<<2), modulo 2^32.
- Jump target = {pc_4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
- redirect_valid = (jump | taken) & ~hold & ~reset. Fetch and the IF/ID and ID/EX registers use it to flush the two younger instructions.
- redirect_pc = the selected target; it is 0 when redirect_valid=0.
- EX/MEM register:
  - Captures alu result, forwarded rt, wb_addr, instr and the four mem/wb controls when hold=0.
  - Holds all fields when hold=1.

## Timing
- Reset, sampled on the falling clk edge, has priority over hold. It sets all exmem_* outputs to 0: result, store data, addr, instr, and all controls.
- redirect outputs are combinational and are 0 while reset=1.
- Latency: one clk from ID/EX inputs to exmem_* outputs.
- Redirect occurs in the same cycle the branch or jump sits in EX.
- Forwarding from exmem_* uses the value registered in the previous cycle. This covers back-to-back ALU dependences with zero stall.
- The hold and redirect conflict is resolved by suppression: a branch present during hold does not redirect. It redirects in the first cycle hold=0, exactly once.
- Writes to $0 are never forwarded, even with reg_write=1.
- A bubble input (all zero) produces exmem_reg_write=0, exmem_mem_write=0, redirect_valid=0.

## Test plan
- Reset: reset=1 for 2 edges with random inputs -> all exmem_* = 0, redirect_valid=0.
- ADD 3+4, then dependent SUB rs=same dest with read_data1 stale=0 -> exmem 7 then 7−rt; EX/MEM forward beats a simultaneous MEM/WB match carrying 99.
- BEQ with rs=rt=5 (forwarded from wb_data), imm=−2, pc_4=0x100 -> redirect_valid=1, redirect_pc=0xF8; BNE same operands -> redirect_valid=0.
- J instr[25:0]=0x0000040, pc_4=0x0040_0010 -> redirect_pc=0x0000_0100; with branch_eq also true, jump target wins.
- hold=1 for 3 cycles with changing inputs and a pending BEQ -> exmem_* frozen and redirect_valid=0; hold drops -> single redirect pulse.
- SLT −1<1 -> 1; SLL 0x1 by 31 -> 0x8000_0000; LUI 0x1234 -> 0x1234_0000; write to $0 with reg_write=1 followed by a use of $0 -> no forwarding, read_data value used.
